// File: rtl/ro_puf_pkg.sv
// ro_puf_pkg -- shared definitions for the ring-oscillator PUF voter.
//   state_t      : controller state encoding
//   vote_width() : width of a per-pair vote counter that can hold 0..NROUND
//   DEF_*        : default parameter values for ro_puf_vote / ro_meas_pair
package ro_puf_pkg;

    localparam int DEF_NROP   = 256;
    localparam int DEF_ACC    = 7;
    localparam int DEF_NDLY   = 4;
    localparam int DEF_NSTOP  = 512;
    localparam int DEF_NROUND = 5;
    localparam int DEF_THRESH = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        MEAS,
        SETTLE,
        EVAL,
        DONE,
        POST
    } state_t;

    // A vote counter must reach NROUND without wrapping.
    function automatic int vote_width(input int nround);
        return $clog2(nround + 1);
    endfunction

endpackage

// File: rtl/ro_meas_pair.sv
// ro_meas_pair -- one ring-oscillator pair with its ripple counters,
// clk-domain count capture and the comparison result.
//   clk : system clock (capture / synchronizer domain)
//   rst : reset; asynchronously clears the ripple counters
//   clr : START-state clear of ripple counters and captured counts
//   en  : oscillator enable (measurement window)
//   e   : 1 when count1 > count2 (ties give 0)
//   co  : |count1 - count2|, modulo 2^ACC
// Build options: SYNTHESIS selects the real oscillators; otherwise a
// simulation model is used whose counts are set through sim_c1 / sim_c2.
module ro_meas_pair
    import ro_puf_pkg::*;
#(
    parameter int ACC  = DEF_ACC,
    parameter int NDLY = DEF_NDLY
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           en,
    output logic           e,
    output logic [ACC-1:0] co
);

    logic [ACC-1:0] cnt1;
    logic [ACC-1:0] cnt2;

`ifndef SYNTHESIS
    // Simulation stand-in for the oscillators: while enabled, the counters
    // take the injected values, so a test can dictate each round's counts.
    localparam int unused_ndly = NDLY;
    logic [ACC-1:0] sim_c1 = '0;
    logic [ACC-1:0] sim_c2 = '0;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt1 <= '0;
            cnt2 <= '0;
        end else if (en) begin
            cnt1 <= sim_c1;
            cnt2 <= sim_c2;
        end
    end
`else
    // Gated ring oscillators: one NAND stage plus NDLY kept delay stages.
    (* keep = "true" *) logic [NDLY:0] ring1;
    (* keep = "true" *) logic [NDLY:0] ring2;
    logic [ACC-1:0] rip1;
    logic [ACC-1:0] rip2;
    logic           aclr;

    assign aclr     = rst | clr;
    assign ring1[0] = ~(ring1[NDLY] & en);
    assign ring2[0] = ~(ring2[NDLY] & en);

    genvar gi;
    for (gi = 0; gi < NDLY; gi++) begin : g_dly
        assign ring1[gi+1] = ring1[gi];
        assign ring2[gi+1] = ring2[gi];
    end

    // Ripple up-counters: bit 0 clocked by the oscillator, each higher bit
    // toggles on the falling edge of the bit below.
    for (gi = 0; gi < ACC; gi++) begin : g_rip
        logic tck1;
        logic tck2;
        if (gi == 0) begin : g_lsb
            assign tck1 = ring1[NDLY];
            assign tck2 = ring2[NDLY];
        end else begin : g_upper
            assign tck1 = ~rip1[gi-1];
            assign tck2 = ~rip2[gi-1];
        end
        always_ff @(posedge tck1 or posedge aclr) begin
            if (aclr) rip1[gi] <= 1'b0;
            else      rip1[gi] <= ~rip1[gi];
        end
        always_ff @(posedge tck2 or posedge aclr) begin
            if (aclr) rip2[gi] <= 1'b0;
            else      rip2[gi] <= ~rip2[gi];
        end
    end

    assign cnt1 = rip1;
    assign cnt2 = rip2;
`endif

    // Two-stage capture. The counts are frozen before they are used (the
    // controller waits out the ripple and these stages), so the multi-bit
    // transfer is coherent by the time e/co are evaluated.
    logic [ACC-1:0] cnt1_meta_reg, cnt1_sync_reg;
    logic [ACC-1:0] cnt2_meta_reg, cnt2_sync_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt1_meta_reg <= '0;
            cnt1_sync_reg <= '0;
            cnt2_meta_reg <= '0;
            cnt2_sync_reg <= '0;
        end else begin
            cnt1_meta_reg <= cnt1;
            cnt1_sync_reg <= cnt1_meta_reg;
            cnt2_meta_reg <= cnt2;
            cnt2_sync_reg <= cnt2_meta_reg;
        end
    end

    assign e  = cnt1_sync_reg > cnt2_sync_reg;
    assign co = e ? (cnt1_sync_reg - cnt2_sync_reg) : (cnt2_sync_reg - cnt1_sync_reg);

endmodule

// File: rtl/ro_puf_vote.sv
// ro_puf_vote -- ring-oscillator PUF with multi-round majority voting.
//   clk, rst          : system clock, synchronous active-high reset
//   req_valid         : measurement request (sampled only in IDLE)
//   req_ready         : one-cycle pulse, request accepted
//   req_busy          : measurement in progress (START .. POST)
//   key_v[NROP]       : majority-voted response bits
//   mask_v[NROP]      : 1 marks a stable, usable bit
//   res_valid         : key_v / mask_v valid (POST)
//   res_ready         : consumer accepts the result
// Build option: RO_PUF_MASK_EN enables per-pair minimum-difference tracking
// and the stability mask; without it mask_v is all ones after a measurement.
module ro_puf_vote
    import ro_puf_pkg::*;
#(
    parameter int NROP   = DEF_NROP,
    parameter int ACC    = DEF_ACC,
    parameter int NDLY   = DEF_NDLY,
    parameter int NSTOP  = DEF_NSTOP,
    parameter int NROUND = DEF_NROUND,
    parameter int THRESH = DEF_THRESH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    output logic            req_busy,
    output logic [NROP-1:0] key_v,
    output logic [NROP-1:0] mask_v,
    output logic            res_valid,
    input  logic            res_ready
);

    localparam int VW = vote_width(NROUND);
    localparam int TW = $clog2(NSTOP + ACC + 3);
    localparam logic [VW-1:0] NROUND_V    = VW'(NROUND);
    localparam logic [VW-1:0] HALF_V      = VW'(NROUND / 2);
    localparam logic [TW-1:0] MEAS_LAST   = TW'(NSTOP - 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(ACC + 1);

    state_t         state_reg, state_next;
    logic [TW-1:0]  tmr_reg, tmr_next;
    logic [VW-1:0]  round_reg;
    logic           req_ready_reg;
    logic           en_reg;
    logic           accept;
    logic           clr;
    logic [NROP-1:0] e;
    logic [ACC-1:0] co [NROP];

    assign accept    = (state_reg == IDLE) && req_valid;
    assign clr       = (state_reg == START);
    assign req_ready = req_ready_reg;
    assign req_busy  = (state_reg != IDLE);
    assign res_valid = (state_reg == POST);

    // Controller state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            tmr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            tmr_reg   <= tmr_next;
        end
    end

    // Next-state logic; tmr counts cycles within MEAS and SETTLE.
    always_comb begin
        state_next = state_reg;
        tmr_next   = tmr_reg;
        unique case (state_reg)
            IDLE:    if (req_valid) state_next = START;
            START: begin
                state_next = MEAS;
                tmr_next   = '0;
            end
            MEAS: begin
                if (tmr_reg == MEAS_LAST) begin
                    state_next = SETTLE;
                    tmr_next   = '0;
                end else begin
                    tmr_next = tmr_reg + TW'(1);
                end
            end
            SETTLE: begin
                if (tmr_reg == SETTLE_LAST) begin
                    state_next = EVAL;
                    tmr_next   = '0;
                end else begin
                    tmr_next = tmr_reg + TW'(1);
                end
            end
            EVAL: begin
                if ((round_reg + VW'(1)) < NROUND_V) state_next = START;
                else                                 state_next = DONE;
            end
            DONE:    state_next = POST;
            POST:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // en is registered from the next state so it is glitch-free and high
    // for exactly the MEAS cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready_reg <= 1'b0;
            en_reg        <= 1'b0;
            round_reg     <= '0;
        end else begin
            req_ready_reg <= accept;
            en_reg        <= (state_next == MEAS);
            if (accept)                 round_reg <= '0;
            else if (state_reg == EVAL) round_reg <= round_reg + VW'(1);
        end
    end

`ifndef RO_PUF_MASK_EN
    localparam int unused_thresh = THRESH;
`endif

    genvar gi;
    for (gi = 0; gi < NROP; gi++) begin : g_pair
        logic [VW-1:0] vote_reg;
        logic          key_bit;
        logic          mask_bit;
        logic          mask_rule;

        ro_meas_pair #(
            .ACC  (ACC),
            .NDLY (NDLY)
        ) u_pair (
            .clk (clk),
            .rst (rst),
            .clr (clr),
            .en  (en_reg),
            .e   (e[gi]),
            .co  (co[gi])
        );

`ifdef RO_PUF_MASK_EN
        logic [ACC-1:0] min_reg;

        always_ff @(posedge clk) begin
            if (rst || accept) begin
                min_reg <= '1;
            end else if (state_reg == EVAL && co[gi] < min_reg) begin
                min_reg <= co[gi];
            end
        end

        // Stable only if every round agreed and no round came close to a tie.
        assign mask_rule = ((vote_reg == '0) || (vote_reg == NROUND_V)) &&
                           (min_reg >= ACC'(THRESH));
`else
        logic unused_co;
        assign unused_co = ^co[gi];
        assign mask_rule = 1'b1;
`endif

        always_ff @(posedge clk) begin
            if (rst) begin
                vote_reg <= '0;
                key_bit  <= 1'b0;
                mask_bit <= 1'b0;
            end else begin
                if (accept) begin
                    vote_reg <= '0;
                end else if (state_reg == EVAL && e[gi] && vote_reg != NROUND_V) begin
                    vote_reg <= vote_reg + VW'(1);
                end
                if (state_reg == DONE) begin
                    key_bit  <= (vote_reg > HALF_V);
                    mask_bit <= mask_rule;
                end
            end
        end

        assign key_v[gi]  = key_bit;
        assign mask_v[gi] = mask_bit;
    end

endmodule

// File: doc/ro_puf_vote.md
RO_PUF_VOTE -- requirements
Module: ro_puf_vote

Interface
REQ-001 SHALL have parameter NROP, default 256: number of ring-oscillator pairs (key bits).
REQ-002 SHALL have parameter ACC, default 7: ripple counter width per oscillator.
REQ-003 SHALL have parameter NDLY, default 4: delay LUTs per oscillator.
REQ-004 SHALL have parameter NSTOP, default 512: enable window per round, in clk cycles.
REQ-005 SHALL have parameter NROUND, default 5: measurement rounds per request; odd, 1..15.
REQ-006 SHALL have parameter THRESH, default 8: minimum per-round count difference for a stable bit.
REQ-007 SHALL have port clk, input, 1 bit: single system clock.
REQ-008 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-009 SHALL have port req_valid, input, 1 bit: measurement request.
REQ-010 SHALL have port req_ready, output, 1 bit: request accepted; one-cycle pulse.
REQ-011 SHALL have port req_busy, output, 1 bit: measurement in progress.
REQ-012 SHALL have port key_v, output, NROP bits: majority-voted response bits.
REQ-013 SHALL have port mask_v, output, NROP bits: stable-bit mask; 1 marks a usable bit.
REQ-014 SHALL have port res_valid, output, 1 bit: key_v and mask_v valid.
REQ-015 SHALL have port res_ready, input, 1 bit: consumer accepts the result.

Function
REQ-016 SHALL implement states IDLE, START, MEAS, SETTLE, EVAL, DONE, POST.
REQ-017 SHALL, in IDLE with req_valid=1, assert req_ready and req_busy on the next cycle, clear round, vote and min registers, and enter START.
REQ-018 SHALL, in START (1 cycle), hold all ripple counters and synced counts cleared, then enter MEAS.
REQ-019 SHALL, in MEAS, hold en=1 for exactly NSTOP cycles, then drop en and enter SETTLE.
REQ-020 SHALL hold SETTLE for ACC+2 cycles (ripple and synchronizer settling), then enter EVAL.
REQ-021 SHALL, in EVAL (1 cycle), per pair: increment vote[i] if e[i]=1, set min_co[i] to min(min_co[i], co[i]), and increment the round counter.
REQ-022 SHALL go from EVAL to START when rounds completed < NROUND, otherwise to DONE.
REQ-023 SHALL, in DONE (1 cycle), register key_v[i] = (vote[i] > NROUND/2) and mask_v[i] = (vote[i]==0 or vote[i]==NROUND) and (min_co[i] >= THRESH), then enter POST.
REQ-024 SHALL keep res_valid=1 in POST with key_v and mask_v stable; on res_ready=1, drop res_valid and req_busy on the next cycle and enter IDLE.
REQ-025 SHALL ignore req_valid outside IDLE; a request held high through POST is accepted on the first IDLE cycle.
REQ-026 SHALL make vote counters clog2(NROUND+1) bits, initialised to 0 and never wrapping.
REQ-027 SHALL make min_co ACC bits, initialised to all ones.
REQ-028 SHALL compute co as modulo-2^ACC unsigned magnitude, with e=1 only when count1 > count2 (ties give e=0).
REQ-029 SHALL give a request with no res_ready a fixed latency: res_valid first high NROUND*(NSTOP+ACC+4)+2 cycles after the cycle req_valid is sampled.

Reset
REQ-030 SHALL, while rst=1, on the clock edge: enter IDLE; set req_ready, req_busy, res_valid and en to 0; set key_v and mask_v to 0; clear all counters. This applies in any state, including mid-MEAS.
REQ-031 SHALL asynchronously clear the per-oscillator ripple counters by rst or the START state; all other state SHALL be reset synchronously.

Configuration
REQ-032 SHALL, with RO_PUF_MASK_EN defined, implement min_co storage and the mask rule of REQ-023.
REQ-033 SHALL, without RO_PUF_MASK_EN, omit min_co, drive mask_v to all ones in DONE (0 in reset), and leave key_v and timing unchanged.

Structure
REQ-034 SHALL define the state enum, vote-width function and default parameter constants in shared package ro_puf_pkg.
REQ-035 SHALL place the two oscillators, two ripple counters, clocked count capture, e and co in sub-module ro_meas_pair, instantiated NROP times; ro_meas_pair SHALL have a SIM-only override for injecting count values.

Verification
REQ-036 SHALL cover: NROUND=3, THRESH=8, pair0 e=1,1,1 with co=20,20,20 -> key_v[0]=1, mask_v[0]=1.
REQ-037 SHALL cover: pair1 e=1,0,1 with co=20 each -> key_v[1]=1, mask_v[1]=0.
REQ-038 SHALL cover: pair2 e=0,0,0 with co=20,5,20 -> key_v[2]=0, mask_v[2]=0; with the macro off, mask_v[2]=1.
REQ-039 SHALL cover: NSTOP=16, ACC=7, NROUND=3, req_valid at cycle 0 -> req_ready high only at cycle 1, res_valid first high at cycle 83.
REQ-040 SHALL cover: res_ready held low 50 cycles -> key_v and mask_v unchanged; req_valid pulse during MEAS -> no second req_ready.
REQ-041 SHALL cover: rst at cycle 30 of MEAS -> next cycle state IDLE with all outputs 0; a new request completes with normal latency.
